// File: rtl/path_replay_buffer_if.sv
//==============================================================================
// Module  : path_replay_buffer_if
// Brief   : Capture/replay bus between pricing core, replay buffer and consumer.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

interface path_replay_buffer_if #(
    parameter int WIDTH = 12,
    parameter int AW    = 11
);
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             resend;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW:0]      count;
    logic             full;
    logic             overflow;
    logic             pass_done;

    modport master (
        output mode, in_valid, in_data, resend, out_ready,
        input  out_data, out_valid, count, full, overflow, pass_done
    );

    modport slave (
        input  mode, in_valid, in_data, resend, out_ready,
        output out_data, out_valid, count, full, overflow, pass_done
    );
endinterface

`default_nettype wire

// File: rtl/path_replay_buffer.sv
//==============================================================================
// Module  : path_replay_buffer
// Brief   : Captures core path samples into on-chip RAM, replays them as a
//           ready/valid stream with full-set rewind on resend.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module path_replay_buffer #(
    parameter int WIDTH  = 12,
    parameter int DAY    = 8,
    parameter int N_PATH = 256,
    parameter int AW     = 11
) (
    input wire                  clk,
    input wire                  rst,
    path_replay_buffer_if.slave bus
);

    localparam int DEPTH = N_PATH * DAY;
    localparam logic [AW:0] c_depth   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] c_one_cnt = (AW + 1)'(1);
    localparam logic [AW-1:0] c_one_wr = AW'(1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_REPLAY  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]       r_state;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      r_rd_ptr;
    logic             r_overflow;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_pass_done;

    logic w_full;
    logic w_mode_cap;
    logic w_mode_rep;
    logic w_load;
    logic w_last;
    logic w_wr_en;

    assign w_full     = (r_count == c_depth);
    assign w_mode_cap = (bus.mode == 2'd1);
    assign w_mode_rep = (bus.mode == 2'd2);
    // rd_ptr runs one ahead of the word in the output register, so the final
    // word is on the bus exactly when rd_ptr has reached count.
    assign w_load     = (!r_out_valid || bus.out_ready) && (r_rd_ptr < r_count);
    assign w_last     = r_out_valid && bus.out_ready && (r_rd_ptr == r_count);
    assign w_wr_en    = (r_state == ST_CAPTURE) && w_mode_cap && bus.in_valid && !w_full;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_pass_done <= 1'b0;
        end else begin
            r_pass_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_mode_cap) begin
                        r_state    <= ST_CAPTURE;
                        r_wr_ptr   <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_mode_rep && (r_count != '0)) begin
                        r_state  <= ST_REPLAY;
                        r_rd_ptr <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_mode_cap) begin
                        if (bus.in_valid) begin
                            if (w_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_wr_ptr <= r_wr_ptr + c_one_wr;
                                r_count  <= r_count + c_one_cnt;
                            end
                        end
                    end else if (w_mode_rep) begin
                        r_state  <= (r_count != '0) ? ST_REPLAY : ST_IDLE;
                        r_rd_ptr <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    // REPLAY and DONE: mode change beats resend, resend beats
                    // a same-cycle final handshake.
                    if (w_mode_cap) begin
                        r_state     <= ST_CAPTURE;
                        r_wr_ptr    <= '0;
                        r_count     <= '0;
                        r_overflow  <= 1'b0;
                        r_out_valid <= 1'b0;
                    end else if (!w_mode_rep) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else if (bus.resend) begin
                        r_state     <= ST_REPLAY;
                        r_rd_ptr    <= '0;
                        r_out_valid <= 1'b0;
                    end else if (r_state == ST_REPLAY) begin
                        if (w_load) begin
                            r_out_data  <= mem[r_rd_ptr[AW-1:0]];
                            r_out_valid <= 1'b1;
                            r_rd_ptr    <= r_rd_ptr + c_one_cnt;
                        end else if (w_last) begin
                            r_out_valid <= 1'b0;
                            r_pass_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.pass_done = r_pass_done;

endmodule

`default_nettype wire

// File: tb/tb_path_replay_buffer.sv
//==============================================================================
// Module  : tb_path_replay_buffer
// Brief   : Directed scoreboard bench for path_replay_buffer.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_path_replay_buffer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    logic [11:0] model[$];
    logic [11:0] exp_q[$];

    path_replay_buffer_if #(.WIDTH(12), .AW(11)) bus ();

    path_replay_buffer #(
        .WIDTH (12),
        .DAY   (8),
        .N_PATH(256),
        .AW    (11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the word on the bus with the scoreboard head; ready must be 1.
    task automatic expect_word(input string tag);
        logic [11:0] e;
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'h000;
        check({tag, "_data"}, 32'(bus.out_data), 32'(e));
        step();
    endtask

    initial begin
        logic [3:0]  pat;
        logic [11:0] held;
        logic [11:0] d;
        bit          have_held;
        int          cyc;

        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.mode      = 2'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.resend    = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_pd", 32'(bus.pass_done), 32'd0);
        rst = 1'b0;
        step();

        // T1 capture 16 samples
        bus.mode = 2'd1;
        step();
        for (int i = 1; i <= 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 12'(i);
            model.push_back(12'(i));
            step();
        end
        bus.in_valid = 1'b0;
        check("t1_count", 32'(bus.count), 32'd16);
        check("t1_full", 32'(bus.full), 32'd0);
        check("t1_ovf", 32'(bus.overflow), 32'd0);

        // T2 full-rate replay
        bus.mode      = 2'd2;
        bus.out_ready = 1'b1;
        exp_q         = model;
        step();
        check("t2_entry_valid", 32'(bus.out_valid), 32'd0);
        step();
        for (int i = 0; i < 16; i++) expect_word("t2");
        check("t2_pd", 32'(bus.pass_done), 32'd1);
        check("t2_end_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("t2_pd_clear", 32'(bus.pass_done), 32'd0);

        // T3 resend from DONE, then backpressure 1,0,0,1
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        check("t3_resend_valid", 32'(bus.out_valid), 32'd0);
        exp_q     = model;
        pat       = 4'b1001;
        have_held = 1'b0;
        held      = '0;
        cyc       = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            bus.out_ready = pat[cyc % 4];
            if (have_held) begin
                check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
                check("t3_hold_data", 32'(bus.out_data), 32'(held));
            end
            have_held = 1'b0;
            if (bus.out_valid) begin
                if (bus.out_ready) begin
                    check("t3_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
                end else begin
                    held      = bus.out_data;
                    have_held = 1'b1;
                end
            end
            step();
            cyc++;
        end
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_pd", 32'(bus.pass_done), 32'd1);
        bus.out_ready = 1'b1;

        // T4 resend mid-pass after five words, then on the last handshake
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        exp_q      = model;
        step();
        for (int i = 0; i < 5; i++) expect_word("t4a");
        bus.resend    = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.resend    = 1'b0;
        bus.out_ready = 1'b1;
        check("t4_gap_valid", 32'(bus.out_valid), 32'd0);
        exp_q = model;
        step();
        for (int i = 0; i < 15; i++) expect_word("t4b");
        check("t4_last_data", 32'(bus.out_data), 32'h010);
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        check("t4_rs_valid", 32'(bus.out_valid), 32'd0);
        check("t4_rs_pd", 32'(bus.pass_done), 32'd0);
        step();
        check("t4_rs_pd2", 32'(bus.pass_done), 32'd0);
        check("t4_restart_valid", 32'(bus.out_valid), 32'd1);
        check("t4_restart_data", 32'(bus.out_data), 32'h001);

        // mode 3 acts as idle; count is kept so replay re-enters from IDLE
        bus.mode = 2'd3;
        step();
        check("m3_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("m3_count", 32'(bus.count), 32'd16);
        bus.mode = 2'd2;
        step();
        step();
        check("idle_rep_valid", 32'(bus.out_valid), 32'd1);
        check("idle_rep_data", 32'(bus.out_data), 32'h001);
        bus.mode = 2'd0;
        step();

        // T5 full / overflow with 2049 samples
        model.delete();
        bus.mode = 2'd1;
        step();
        for (int i = 0; i < 2049; i++) begin
            d            = 12'((i * 37 + 5) & 12'hFFF);
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            if (i < 2048) model.push_back(d);
            step();
            if (i == 2047) begin
                check("t5_count_at_full", 32'(bus.count), 32'd2048);
                check("t5_full", 32'(bus.full), 32'd1);
                check("t5_ovf_before", 32'(bus.overflow), 32'd0);
            end
        end
        bus.in_valid = 1'b0;
        check("t5_count", 32'(bus.count), 32'd2048);
        check("t5_ovf", 32'(bus.overflow), 32'd1);
        bus.mode = 2'd2;
        exp_q    = model;
        step();
        check("t5_entry_valid", 32'(bus.out_valid), 32'd0);
        step();
        for (int i = 0; i < 2048; i++) expect_word("t5");
        check("t5_pd", 32'(bus.pass_done), 32'd1);
        check("t5_end_valid", 32'(bus.out_valid), 32'd0);

        // T6 reset during streaming
        bus.resend = 1'b1;
        step();
        bus.resend = 1'b0;
        exp_q      = model;
        step();
        for (int i = 0; i < 3; i++) expect_word("t6");
        rst = 1'b1;
        step();
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_count", 32'(bus.count), 32'd0);
        check("t6_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_idle_valid", 32'(bus.out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
